// File: rtl/riscv_crypto_aes32_pkg.sv
// ---------------------------------------------------------------------------
// riscv_crypto_aes32_pkg
// Shared definitions for the 32-bit AES round unit: operation encodings,
// operation field positions, the stage-1 register struct and the GF(2^8)
// helpers used by the S-box and column-multiply logic.
// ---------------------------------------------------------------------------
package riscv_crypto_aes32_pkg;

   localparam logic [1:0] AES32_OP_ESI  = 2'b00;
   localparam logic [1:0] AES32_OP_ESMI = 2'b01;
   localparam logic [1:0] AES32_OP_DSI  = 2'b10;
   localparam logic [1:0] AES32_OP_DSMI = 2'b11;

   localparam int AES32_OP_DEC = 1;
   localparam int AES32_OP_MIX = 0;

   // Stage-1 payload: S-box output plus the fields stage 2 still needs.
   typedef struct packed {
      logic [31:0] rs1;
      logic [7:0]  s;
      logic [1:0]  bs;
      logic [1:0]  op;
   } aes32_s1_t;

   // Multiply by x modulo x^8+x^4+x^3+x+1 (0x11B).
   function automatic logic [7:0] aes_xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] aes_gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] aa;
      p  = 8'h00;
      aa = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ aa;
         aa = aes_xtime(aa);
      end
      return p;
   endfunction

   // Multiplicative inverse as a^254 (a^2 * a^4 * ... * a^128); maps 0 to 0.
   function automatic logic [7:0] aes_gf_inv(input logic [7:0] a);
      logic [7:0] sq;
      logic [7:0] acc;
      sq  = a;
      acc = 8'h01;
      for (int i = 1; i < 8; i++) begin
         sq  = aes_gf_mul(sq, sq);
         acc = aes_gf_mul(acc, sq);
      end
      return acc;
   endfunction

   function automatic logic [7:0] aes_rol8(input logic [7:0] a, input int n);
      logic [15:0] t;
      t = {a, a} << n;
      return t[15:8];
   endfunction

endpackage

// File: rtl/riscv_crypto_aes_mixcol_byte.sv
// ---------------------------------------------------------------------------
// riscv_crypto_aes_mixcol_byte
// One column of (Inv)MixColumns applied to a single non-zero byte position.
//   s   : S-box output byte
//   dec : 1 selects InvMixColumns coefficients
//   m   : column word, most significant byte first
//         enc {3s, s, s, 2s}   dec {0B s, 0D s, 09 s, 0E s}
// ---------------------------------------------------------------------------
module riscv_crypto_aes_mixcol_byte
   import riscv_crypto_aes32_pkg::*;
(
   input  logic [7:0]  s,
   input  logic        dec,
   output logic [31:0] m
);
   logic [7:0] x2, x4, x8;

   // Shared xtime chain; every coefficient is an XOR of these terms.
   assign x2 = aes_xtime(s);
   assign x4 = aes_xtime(x2);
   assign x8 = aes_xtime(x4);

   always_comb begin
      if (dec) m = {x8 ^ x2 ^ s, x8 ^ x4 ^ s, x8 ^ s, x8 ^ x4 ^ x2};
      else     m = {x2 ^ s, s, s, x2};
   end
endmodule

// File: rtl/riscv_crypto_aes_sbox.sv
// ---------------------------------------------------------------------------
// riscv_crypto_aes_fwd_sbox / riscv_crypto_aes_inv_sbox
// Combinational AES S-boxes built from the GF(2^8) inverse and the affine map.
//   in : input byte
//   fx : substituted byte
// ---------------------------------------------------------------------------
module riscv_crypto_aes_fwd_sbox
   import riscv_crypto_aes32_pkg::*;
(
   input  logic [7:0] in,
   output logic [7:0] fx
);
   logic [7:0] inv;

   assign inv = aes_gf_inv(in);
   assign fx  = inv ^ aes_rol8(inv, 1) ^ aes_rol8(inv, 2) ^ aes_rol8(inv, 3)
              ^ aes_rol8(inv, 4) ^ 8'h63;
endmodule

module riscv_crypto_aes_inv_sbox
   import riscv_crypto_aes32_pkg::*;
(
   input  logic [7:0] in,
   output logic [7:0] fx
);
   logic [7:0] aff;

   // Inverse affine map first, then field inversion.
   assign aff = aes_rol8(in, 1) ^ aes_rol8(in, 3) ^ aes_rol8(in, 6) ^ 8'h05;
   assign fx  = aes_gf_inv(aff);
endmodule

// File: rtl/riscv_crypto_fu_aes32_pipe.sv
// ---------------------------------------------------------------------------
// riscv_crypto_fu_aes32_pipe
// Two-stage AES32 round unit (aes32esi/esmi/dsi/dsmi).
//   g_clk, g_resetn : clock, async active-low reset
//   flush           : kill in-flight ops (stage 2 too when FLUSH_OUT=1)
//   in_valid/ready  : issue handshake; in_rs1 accumulator, in_rs2 byte
//                     source, in_bs byte select, in_op operation
//   out_valid/ready : result handshake; out_rd result
// Stage 1 registers the selected byte's S-box output; stage 2 applies the
// optional column multiply, rotates by bs bytes and XORs into rs1.
// ---------------------------------------------------------------------------
module riscv_crypto_fu_aes32_pipe
   import riscv_crypto_aes32_pkg::*;
#(
   parameter bit FLUSH_OUT = 1'b1
) (
   input  logic        g_clk,
   input  logic        g_resetn,
   input  logic        flush,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_rs1,
   input  logic [31:0] in_rs2,
   input  logic [1:0]  in_bs,
   input  logic [1:0]  in_op,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_rd
);
   localparam int STAGES = 2;

   // vld_pipe[1] = stage-1 occupied, vld_pipe[2] = result held in out_rd.
   logic [STAGES:1] vld_pipe;
   aes32_s1_t       s1_q;

   logic        s1_ready, s2_ready, s1_load, s1_move;
   logic [7:0]  sb_in, sb_fwd, sb_inv;
   logic [31:0] col, m, m_rot, rd_next;

   // Ready chain depends only on state, out_ready and flush, never in_valid.
   assign s2_ready  = !vld_pipe[2] || out_ready;
   assign s1_ready  = !vld_pipe[1] || s2_ready;
   assign in_ready  = s1_ready && !flush;
   assign s1_load   = in_valid && in_ready;
   assign s1_move   = vld_pipe[1] && s2_ready;
   assign out_valid = vld_pipe[2];

   // ---------------- stage 1: byte select + S-box ----------------
   always_comb begin
      sb_in = in_rs2[7:0];
      case (in_bs)
         2'd1:    sb_in = in_rs2[15:8];
         2'd2:    sb_in = in_rs2[23:16];
         2'd3:    sb_in = in_rs2[31:24];
         default: sb_in = in_rs2[7:0];
      endcase
   end

   riscv_crypto_aes_fwd_sbox u_fwd_sbox (.in(sb_in), .fx(sb_fwd));
   riscv_crypto_aes_inv_sbox u_inv_sbox (.in(sb_in), .fx(sb_inv));

   // Payload needs no reset: it is only observed behind vld_pipe.
   always_ff @(posedge g_clk) begin
      if (s1_load) begin
         s1_q.rs1 <= in_rs1;
         s1_q.s   <= in_op[AES32_OP_DEC] ? sb_inv : sb_fwd;
         s1_q.bs  <= in_bs;
         s1_q.op  <= in_op;
      end
   end

   // ---------------- stage 2: mix, rotate, xor ----------------
   riscv_crypto_aes_mixcol_byte u_mixcol (
      .s   (s1_q.s),
      .dec (s1_q.op[AES32_OP_DEC]),
      .m   (col)
   );

   assign m = s1_q.op[AES32_OP_MIX] ? col : {24'h0, s1_q.s};

   // Rotate left by 8*bs.
   always_comb begin
      m_rot = m;
      case (s1_q.bs)
         2'd1:    m_rot = {m[23:0], m[31:24]};
         2'd2:    m_rot = {m[15:0], m[31:16]};
         2'd3:    m_rot = {m[7:0],  m[31:8]};
         default: m_rot = m;
      endcase
   end

   assign rd_next = s1_q.rs1 ^ m_rot;

   // ---------------- valid bits and result ----------------
   always_ff @(posedge g_clk or negedge g_resetn) begin
      if (!g_resetn) begin
         vld_pipe <= '0;
         out_rd   <= 32'h0;
      end else if (flush) begin
         // Stage-1 contents are dropped, so nothing moves into stage 2.
         vld_pipe[1] <= 1'b0;
         if (FLUSH_OUT)      vld_pipe[2] <= 1'b0;
         else if (out_ready) vld_pipe[2] <= 1'b0;
      end else begin
         if (s1_load)      vld_pipe[1] <= 1'b1;
         else if (s1_move) vld_pipe[1] <= 1'b0;

         if (s1_move) begin
            vld_pipe[2] <= 1'b1;
            out_rd      <= rd_next;
         end else if (out_ready) begin
            vld_pipe[2] <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_riscv_crypto_fu_aes32_pipe.sv
module tb_riscv_crypto_fu_aes32_pipe;

   logic        g_clk = 1'b0;
   logic        g_resetn = 1'b0;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_rs1 = '0;
   logic [31:0] in_rs2 = '0;
   logic [1:0]  in_bs = '0;
   logic [1:0]  in_op = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_rd;

   int checks = 0;
   int errors = 0;

   int sbox_t[256];
   int isbox_t[256];
   logic [31:0] exp_q[$];

   always #5 g_clk = ~g_clk;

   riscv_crypto_fu_aes32_pipe dut (
      .g_clk     (g_clk),
      .g_resetn  (g_resetn),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_rs1    (in_rs1),
      .in_rs2    (in_rs2),
      .in_bs     (in_bs),
      .in_op     (in_op),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_rd    (out_rd)
   );

   // ---------------- reference model ----------------
   function automatic int gmul(int a, int b);
      int p;
      p = 0;
      for (int i = 0; i < 8; i++) begin
         if ((b >> i) & 1) p = p ^ a;
         a = a << 1;
         if (a & 'h100) a = a ^ 'h11b;
      end
      return p & 'hff;
   endfunction

   // S-box from its definition: brute-force inverse, then affine bit formula.
   task automatic build_tables();
      int inv;
      int s;
      int bt;
      for (int x = 0; x < 256; x++) begin
         inv = 0;
         for (int y = 1; y < 256; y++) if (gmul(x, y) == 1) inv = y;
         s = 0;
         for (int i = 0; i < 8; i++) begin
            bt = ((inv >> i) ^ (inv >> ((i + 4) % 8)) ^ (inv >> ((i + 5) % 8))
                 ^ (inv >> ((i + 6) % 8)) ^ (inv >> ((i + 7) % 8)) ^ ('h63 >> i)) & 1;
            s = s | (bt << i);
         end
         sbox_t[x]  = s;
         isbox_t[s] = x;
      end
   endtask

   function automatic logic [31:0] ref_rd(logic [31:0] rs1, logic [31:0] rs2,
                                          logic [1:0] bs, logic [1:0] op);
      int b;
      int s;
      logic [31:0] m;
      logic [63:0] t;
      b = int'((rs2 >> (8 * bs)) & 32'hff);
      s = op[1] ? isbox_t[b] : sbox_t[b];
      case (op)
         2'b01:   m = 32'((gmul(3, s) << 24) | (s << 16) | (s << 8) | gmul(2, s));
         2'b11:   m = 32'((gmul(11, s) << 24) | (gmul(13, s) << 16) | (gmul(9, s) << 8) | gmul(14, s));
         default: m = 32'(s);
      endcase
      t = {m, m} << (8 * bs);
      return rs1 ^ t[63:32];
   endfunction

   task automatic step();
      @(posedge g_clk);
      #1;
   endtask

   task automatic rand_op();
      in_rs1 = $urandom;
      in_rs2 = $urandom;
      in_bs  = 2'($urandom_range(0, 3));
      in_op  = 2'($urandom_range(0, 3));
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      g_resetn = 1'b0;
      repeat (2) @(posedge g_clk);
      #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
      checks++; if (out_rd !== 32'h0) begin errors++; $display("FAIL reset_rd: got %h expected 00000000", out_rd); end
      g_resetn = 1'b1;
      @(negedge g_clk);
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
      step();
   endtask

   task automatic test_single();
      logic [31:0] gold [4];
      gold = '{32'h00000063, 32'hA56363C6, 32'h00000052, 32'h50A7F451};
      out_ready = 1'b1;
      for (int op = 0; op < 4; op++) begin
         in_rs1 = '0; in_rs2 = '0; in_bs = '0; in_op = 2'(op); in_valid = 1'b1;
         @(negedge g_clk);
         checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL single_accept op=%0d: got %b expected 1", op, in_ready); end
         step();
         in_valid = 1'b0;
         @(negedge g_clk);
         checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_early op=%0d: got %b expected 0", op, out_valid); end
         step();
         @(negedge g_clk);
         checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid op=%0d: got %b expected 1", op, out_valid); end
         checks++; if (out_rd !== gold[op]) begin errors++; $display("FAIL single_rd op=%0d: got %h expected %h", op, out_rd, gold[op]); end
         step();
      end
   endtask

   task automatic test_rotate();
      logic [31:0] exp;
      out_ready = 1'b1;
      for (int k = 0; k < 17; k++) begin
         if (k == 0) begin
            in_rs1 = 32'hFFFFFFFF; in_rs2 = '0; in_bs = 2'd3; in_op = 2'b01;
            exp = 32'h395A9C9C;
         end else begin
            rand_op();
            in_bs = 2'((k - 1) % 4);
            in_op = 2'((k - 1) / 4);
            exp = ref_rd(in_rs1, in_rs2, in_bs, in_op);
         end
         in_valid = 1'b1;
         step();
         in_valid = 1'b0;
         step();
         @(negedge g_clk);
         checks++;
         if (out_valid !== 1'b1 || out_rd !== exp) begin
            errors++;
            $display("FAIL rotate k=%0d: got v=%b rd=%h expected v=1 rd=%h", k, out_valid, out_rd, exp);
         end
         step();
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] exp;
      exp_q.delete();
      out_ready = 1'b1;
      for (int c = 0; c < 102; c++) begin
         if (c < 100) begin rand_op(); in_valid = 1'b1; end
         else in_valid = 1'b0;
         @(negedge g_clk);
         if (in_valid && in_ready) exp_q.push_back(ref_rd(in_rs1, in_rs2, in_bs, in_op));
         if (c >= 2) begin
            checks++;
            if (out_valid !== 1'b1 || exp_q.size() == 0) begin
               errors++;
               $display("FAIL b2b_valid c=%0d: got v=%b queued=%0d expected v=1", c, out_valid, exp_q.size());
            end else begin
               exp = exp_q.pop_front();
               checks++;
               if (out_rd !== exp) begin errors++; $display("FAIL b2b_rd c=%0d: got %h expected %h", c, out_rd, exp); end
            end
         end
         step();
      end
      @(negedge g_clk);
      checks++; if (out_valid !== 1'b0 || exp_q.size() != 0) begin errors++; $display("FAIL b2b_drain: got v=%b left=%0d expected v=0 left=0", out_valid, exp_q.size()); end
      step();
   endtask

   task automatic test_backpressure();
      int accepts;
      logic [31:0] exp;
      exp_q.delete();
      accepts = 0;
      out_ready = 1'b0;
      rand_op(); in_valid = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(negedge g_clk);
         if (in_valid && in_ready) begin
            accepts++;
            exp_q.push_back(ref_rd(in_rs1, in_rs2, in_bs, in_op));
         end
         if (c >= 2) begin
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready c=%0d: got %b expected 0", c, in_ready); end
            checks++;
            if (out_valid !== 1'b1 || out_rd !== exp_q[0]) begin
               errors++;
               $display("FAIL bp_hold c=%0d: got v=%b rd=%h expected v=1 rd=%h", c, out_valid, out_rd, exp_q[0]);
            end
         end
         step();
         if (accepts > 0 && accepts == exp_q.size() && c < 1) rand_op();
      end
      checks++; if (accepts != 2) begin errors++; $display("FAIL bp_accepts: got %0d expected 2", accepts); end
      // Release: third op accepted in the same cycle as the first pop.
      out_ready = 1'b1;
      @(negedge g_clk);
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b expected 1", in_ready); end
      if (in_valid && in_ready) exp_q.push_back(ref_rd(in_rs1, in_rs2, in_bs, in_op));
      for (int c = 0; c < 3; c++) begin
         if (c > 0) @(negedge g_clk);
         exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hx;
         checks++;
         if (out_valid !== 1'b1 || out_rd !== exp) begin
            errors++;
            $display("FAIL bp_drain n=%0d: got v=%b rd=%h expected v=1 rd=%h", c, out_valid, out_rd, exp);
         end
         step();
         in_valid = 1'b0;
      end
      @(negedge g_clk);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_empty: got %b expected 0", out_valid); end
      step();
   endtask

   task automatic test_flush();
      logic [31:0] exp;
      out_ready = 1'b0;
      for (int c = 0; c < 2; c++) begin
         rand_op(); in_valid = 1'b1;
         step();
      end
      // Both stages full, result not taken; flush with a new op offered.
      rand_op(); in_valid = 1'b1; flush = 1'b1;
      @(negedge g_clk);
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready: got %b expected 0", in_ready); end
      step();
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge g_clk);
         checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_emit c=%0d: got %b expected 0", c, out_valid); end
         step();
      end
      rand_op(); in_valid = 1'b1;
      exp = ref_rd(in_rs1, in_rs2, in_bs, in_op);
      step();
      in_valid = 1'b0;
      step();
      @(negedge g_clk);
      checks++;
      if (out_valid !== 1'b1 || out_rd !== exp) begin
         errors++;
         $display("FAIL flush_next: got v=%b rd=%h expected v=1 rd=%h", out_valid, out_rd, exp);
      end
      step();
   endtask

   task automatic test_reset_mid();
      logic [31:0] exp;
      out_ready = 1'b1;
      rand_op(); in_valid = 1'b1;
      step();
      rand_op();
      step();
      in_valid = 1'b0;
      // Stage 2 now holds a result; reset asynchronously between edges.
      #2;
      g_resetn = 1'b0;
      #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid: got %b expected 0", out_valid); end
      checks++; if (out_rd !== 32'h0) begin errors++; $display("FAIL rst_mid_rd: got %h expected 00000000", out_rd); end
      #1;
      g_resetn = 1'b1;
      step();
      for (int c = 0; c < 2; c++) begin
         @(negedge g_clk);
         checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_emit c=%0d: got %b expected 0", c, out_valid); end
         checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_ready c=%0d: got %b expected 1", c, in_ready); end
         step();
      end
      rand_op(); in_valid = 1'b1;
      exp = ref_rd(in_rs1, in_rs2, in_bs, in_op);
      step();
      in_valid = 1'b0;
      step();
      @(negedge g_clk);
      checks++;
      if (out_valid !== 1'b1 || out_rd !== exp) begin
         errors++;
         $display("FAIL rst_mid_next: got v=%b rd=%h expected v=1 rd=%h", out_valid, out_rd, exp);
      end
      step();
   endtask

   initial begin
      build_tables();
      test_reset();
      test_single();
      test_rotate();
      test_back_to_back();
      test_backpressure();
      test_flush();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
